// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller and its ALU decoder.
package mips_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned ALUC_W  = 3;
    localparam int unsigned ALUOP_W = 2;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEXEC,
        S_ADDIWB,
        S_JUMP
    } state_t;

    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;

    localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

    localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

    // True for opcodes the controller knows how to sequence.
    function automatic logic op_supported(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU decoder: ALUOp + funct -> 3-bit ALU operation code.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [2:0] alu_control_o,
    output logic       funct_valid_o
);

    logic [ALUC_W-1:0] funct_code;

    // R-type funct lookup; unknown functs fall back to ADD and flag invalid.
    always_comb begin
        funct_code    = ALU_ADD;
        funct_valid_o = 1'b1;
        case (funct_i)
            F_ADD:   funct_code = ALU_ADD;
            F_SUB:   funct_code = ALU_SUB;
            F_AND:   funct_code = ALU_AND;
            F_OR:    funct_code = ALU_OR;
            F_SLT:   funct_code = ALU_SLT;
            default: funct_valid_o = 1'b0;
        endcase
    end

    // Select between fixed add/sub and the funct-derived code.
    always_comb begin
        alu_control_o = ALU_ADD;
        case (alu_op_i)
            ALUOP_SUB:   alu_control_o = ALU_SUB;
            ALUOP_FUNCT: alu_control_o = funct_code;
            default:     alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS Moore controller: state register, transitions, output decode.
module multicycle_control_unit
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] ALU_control,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic       illegal_op
);

    state_t               state_q;
    logic                 is_lw_q;
    logic                 funct_ok_q;
    logic [ALUOP_W-1:0]   alu_op;
    logic                 funct_valid;
    logic                 pc_write;
    logic                 branch;

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct_i       (funct),
        .alu_control_o (ALU_control),
        .funct_valid_o (funct_valid)
    );

    // State transitions; lw/sw and funct validity are captured while IR is known stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            is_lw_q    <= 1'b0;
            funct_ok_q <= 1'b1;
        end else begin
            case (state_q)
                S_FETCH:    state_q <= S_DECODE;
                S_DECODE: begin
                    is_lw_q <= (opcode == OP_LW);
                    case (opcode)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_RTYPE:     state_q <= S_EXECUTE;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDIEXEC;
                        OP_J:         state_q <= S_JUMP;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR:   state_q <= is_lw_q ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  state_q <= S_MEMWB;
                S_EXECUTE: begin
                    funct_ok_q <= funct_valid;
                    state_q    <= S_ALUWB;
                end
                S_ADDIEXEC: state_q <= S_ADDIWB;
                default:    state_q <= S_FETCH;
            endcase
        end
    end

    // ALUOp selection per state; reset forces the ADD default.
    always_comb begin
        alu_op = ALUOP_ADD;
        if (!rst) begin
            case (state_q)
                S_EXECUTE: alu_op = ALUOP_FUNCT;
                S_BRANCH:  alu_op = ALUOP_SUB;
                default:   alu_op = ALUOP_ADD;
            endcase
        end
    end

    // Moore output decode from the state register; everything idles while in reset.
    always_comb begin
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal_op = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcB  = 2'b01;
                    IRWrite  = 1'b1;
                    pc_write = 1'b1;
                end
                S_DECODE: begin
                    ALUSrcB    = 2'b11;
                    illegal_op = !op_supported(opcode) ||
                                 ((opcode == OP_RTYPE) && !funct_valid);
                end
                S_MEMADR, S_ADDIEXEC: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                end
                S_MEMREAD:  IorD = 1'b1;
                S_MEMWB: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                S_MEMWRITE: begin
                    IorD     = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECUTE:  ALUSrcA = 1'b1;
                S_ALUWB: begin
                    RegDst   = 1'b1;
                    RegWrite = funct_ok_q;
                end
                S_BRANCH: begin
                    ALUSrcA = 1'b1;
                    branch  = 1'b1;
                    PCSrc   = 2'b01;
                end
                S_ADDIWB:   RegWrite = 1'b1;
                S_JUMP: begin
                    pc_write = 1'b1;
                    PCSrc    = 2'b10;
                end
                default: ;
            endcase
        end
        PCEn = pc_write | (branch & zero);
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit against a cycle-indexed instruction model.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic [2:0] ALU_control;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic       PCEn, illegal_op;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] alu;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       illegal;
    } ctl_t;

    always #5 clk = ~clk;

    multicycle_control_unit dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .ALU_control (ALU_control),
        .IorD        (IorD),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSrc       (PCSrc),
        .PCEn        (PCEn),
        .illegal_op  (illegal_op)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic ctl_t observed();
        ctl_t v;
        v.alu      = ALU_control;
        v.iord     = IorD;
        v.memwrite = MemWrite;
        v.irwrite  = IRWrite;
        v.regdst   = RegDst;
        v.memtoreg = MemtoReg;
        v.regwrite = RegWrite;
        v.alusrca  = ALUSrcA;
        v.alusrcb  = ALUSrcB;
        v.pcsrc    = PCSrc;
        v.pcen     = PCEn;
        v.illegal  = illegal_op;
        return v;
    endfunction

    function automatic ctl_t idle_ctl();
        ctl_t v = '0;
        v.alu = 3'b010;
        return v;
    endfunction

    function automatic bit funct_ok(input logic [5:0] fn);
        return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
               fn == 6'b100101 || fn == 6'b101010;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Cycles taken by an instruction, by opcode.
    function automatic int latency(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011, 6'b000000, 6'b001000: return 4;
            6'b000100, 6'b000010: return 3;
            default: return 2;
        endcase
    endfunction

    // Expected controls for cycle `cyc` (1-based) of an instruction.
    function automatic ctl_t expect_ctl(input logic [5:0] op, input logic [5:0] fn,
                                        input int cyc, input logic z);
        ctl_t v = idle_ctl();
        if (cyc == 1) begin
            v.alusrcb = 2'b01;
            v.irwrite = 1'b1;
            v.pcen    = 1'b1;
        end else if (cyc == 2) begin
            v.alusrcb = 2'b11;
            v.illegal = (latency(op) == 2) || (op == 6'b000000 && !funct_ok(fn));
        end else begin
            case (op)
                6'b100011, 6'b101011, 6'b001000: begin
                    if (cyc == 3) begin
                        v.alusrca = 1'b1;
                        v.alusrcb = 2'b10;
                    end else if (op == 6'b100011 && cyc == 4) begin
                        v.iord = 1'b1;
                    end else if (op == 6'b100011) begin
                        v.memtoreg = 1'b1;
                        v.regwrite = 1'b1;
                    end else if (op == 6'b101011) begin
                        v.iord     = 1'b1;
                        v.memwrite = 1'b1;
                    end else begin
                        v.regwrite = 1'b1;
                    end
                end
                6'b000000: begin
                    if (cyc == 3) begin
                        v.alusrca = 1'b1;
                        v.alu     = funct_alu(fn);
                    end else begin
                        v.regdst   = 1'b1;
                        v.regwrite = funct_ok(fn);
                    end
                end
                6'b000100: begin
                    v.alusrca = 1'b1;
                    v.alu     = 3'b110;
                    v.pcsrc   = 2'b01;
                    v.pcen    = z;
                end
                default: begin
                    v.pcsrc = 2'b10;
                    v.pcen  = 1'b1;
                end
            endcase
        end
        return v;
    endfunction

    // Run one instruction; zmode 0/1 forces zero, 2 randomizes it; abort_at>0 asserts reset at that cycle.
    task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                             input int zmode, input int abort_at);
        int n;
        n = latency(op);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                rst = 1'b1;
                for (int r = 0; r < 2; r++) begin
                    if (r > 0) @(negedge clk);
                    opcode = 6'($urandom);
                    zero   = 1'($urandom);
                    #1;
                    check_eq($sformatf("%s_abort_c%0d_r%0d", name, c, r), 32'(observed()), 32'(idle_ctl()));
                end
                return;
            end
            rst    = 1'b0;
            opcode = op;
            funct  = fn;
            zero   = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            check_eq($sformatf("%s_op%b_fn%b_c%0d", name, op, fn, c),
                     32'(observed()), 32'(expect_ctl(op, fn, c, zero)));
        end
    endtask

    logic [5:0] legal_ops [6];
    logic [5:0] legal_fns [5];

    initial begin
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        legal_fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        // Reset held for two cycles with arbitrary inputs.
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            opcode = 6'($urandom);
            zero   = 1'($urandom);
            #1;
            check_eq($sformatf("reset_r%0d", r), 32'(observed()), 32'(idle_ctl()));
        end

        run_instr("lw",      6'b100011, 6'b000000, 2, 0);
        run_instr("slt",     6'b000000, 6'b101010, 2, 0);
        run_instr("sub",     6'b000000, 6'b100010, 2, 0);
        run_instr("or",      6'b000000, 6'b100101, 2, 0);
        run_instr("rbad",    6'b000000, 6'b111000, 2, 0);
        run_instr("beq_t",   6'b000100, 6'b000000, 1, 0);
        run_instr("beq_nt",  6'b000100, 6'b000000, 0, 0);
        run_instr("sw",      6'b101011, 6'b000000, 2, 0);
        run_instr("illegal", 6'b111111, 6'b000000, 2, 0);
        run_instr("addi",    6'b001000, 6'b000000, 2, 0);
        run_instr("j",       6'b000010, 6'b000000, 2, 0);
        run_instr("lw_abt",  6'b100011, 6'b000000, 2, 4);
        run_instr("lw_post", 6'b100011, 6'b000000, 2, 0);

        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int         abort_at;
            int         sel;
            sel = $urandom_range(0, 6);
            op  = (sel == 6) ? 6'($urandom) : legal_ops[sel];
            fn  = ($urandom_range(0, 1) == 0) ? legal_fns[$urandom_range(0, 4)] : 6'($urandom);
            abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, latency(op)) : 0;
            run_instr($sformatf("rnd%0d", i), op, fn, 2, abort_at);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
